scoreboard_alloc: RTL

Slot allocator that owns the scoreboard occupancy vector for outstanding buffet fill/read requests.
- Hands out a free slot index on an allocate handshake and stores a per-slot payload (request metadata) in that slot.
- Frees a slot and returns its payload when the matching response comes back.
- Free-slot selection uses the existing priorityEncoder, which sits directly downstream of the occupancy register.

---
 rtl/scoreboard_alloc_pkg.sv | 24 ++
 rtl/priorityEncoder.sv | 21 ++
 rtl/scoreboard_alloc.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/scoreboard_alloc_pkg.sv
// Shared buffet scoreboard definitions: default slot count, payload width,
// index-width helper and the per-cycle release classification.
package scoreboard_alloc_pkg;

  // Default number of outstanding buffet fill/read requests tracked.
  localparam int SCOREBOARD_SIZE = 8;

  // Default width of the request metadata held per slot.
  localparam int SB_DATA_WIDTH = 32;

  // Index width for a scoreboard of n slots.
  // n is never below 2, so this is simply ceil(log2(n)).
  function automatic int sb_idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // What a release request does in the current cycle.
  typedef enum logic [1:0] {
    REL_NONE = 2'd0,  // no release presented
    REL_HIT  = 2'd1,  // release of an occupied slot: frees it
    REL_MISS = 2'd2   // release of a free or out-of-range slot: error pulse
  } rel_kind_e;

endpackage

// File: rtl/priorityEncoder.sv
// Priority encoder: returns the index of the highest set bit of req.
// When no bit is set the output is 0; callers must qualify it themselves.
module priorityEncoder #(
  parameter  int WIDTH     = 8,
  localparam int OUT_WIDTH = (WIDTH < 2) ? 1 : $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     req,
  output logic [OUT_WIDTH-1:0] enc
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        enc = OUT_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/scoreboard_alloc.sv
// Scoreboard slot allocator for outstanding buffet fill/read requests.
//
// Owns the occupancy vector and a per-slot payload register array.
// Allocate hands out the highest-indexed free slot and stores the request
// metadata there; release frees a slot and returns its metadata the same
// cycle.
//
// Handshake: an allocate fires on a rising edge where alloc_valid and
// alloc_ready are both high; alloc_idx names the slot granted by that edge.
// alloc_ready depends only on registered state (it is !full), so the
// requester may hold alloc_valid/alloc_data until it sees alloc_ready.
// rel_valid has no ready: a release is always accepted, and a release of a
// slot that is not occupied is reported by a one-cycle rel_err pulse on the
// following cycle.
//
// There is no bypass from release to allocate: a slot freed at an edge is
// first visible to the encoder in the following cycle.
module scoreboard_alloc
  import scoreboard_alloc_pkg::*;
#(
  parameter  int SB_SIZE    = SCOREBOARD_SIZE,
  parameter  int DATA_WIDTH = SB_DATA_WIDTH,
  localparam int IDX_WIDTH  = sb_idx_width(SB_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_valid,
  input  logic [DATA_WIDTH-1:0] alloc_data,
  output logic                  alloc_ready,
  output logic [IDX_WIDTH-1:0]  alloc_idx,
  input  logic                  rel_valid,
  input  logic [IDX_WIDTH-1:0]  rel_idx,
  output logic [DATA_WIDTH-1:0] rel_data,
  output logic                  rel_err,
  output logic [SB_SIZE-1:0]    occupancy,
  output logic [IDX_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty
);

  // Slot count expressed in the count's width for compares.
  localparam logic [IDX_WIDTH:0] SB_SIZE_C = (IDX_WIDTH+1)'(SB_SIZE);

  // Registered state.
  logic [SB_SIZE-1:0]    occ_q;
  logic [IDX_WIDTH:0]    count_q;
  logic                  rel_err_q;
  logic [DATA_WIDTH-1:0] payload [SB_SIZE];

  // Per-cycle decode.
  logic                  alloc_fire;
  logic                  rel_in_range;
  logic [IDX_WIDTH-1:0]  rel_sel;
  rel_kind_e             rel_kind;
  logic                  rel_hit;
  logic                  rel_miss;
  logic [SB_SIZE-1:0]    occ_free;
  logic [SB_SIZE-1:0]    occ_next;

  // Free-slot selection: highest free slot of the registered occupancy.
  assign occ_free = ~occ_q;

  priorityEncoder #(
    .WIDTH (SB_SIZE)
  ) u_free_enc (
    .req (occ_free),
    .enc (alloc_idx)
  );

  // Status decoded from the registered count only.
  assign full        = (count_q == SB_SIZE_C);
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Out-of-range indices (non-power-of-2 sizes) are steered to slot 0 for
  // the read path, and classified as a miss below.
  assign rel_in_range = ({1'b0, rel_idx} < SB_SIZE_C);
  assign rel_sel      = rel_in_range ? rel_idx : '0;

  // Classify this cycle's release request.
  always_comb begin
    rel_kind = REL_NONE;
    if (rel_valid) begin
      if (rel_in_range && occ_q[rel_sel]) begin
        rel_kind = REL_HIT;
      end else begin
        rel_kind = REL_MISS;
      end
    end
  end

  assign rel_hit  = (rel_kind == REL_HIT);
  assign rel_miss = (rel_kind == REL_MISS);

  // Release read port: combinational payload of the addressed slot.
  assign rel_data = payload[rel_sel];

  // Next occupancy: set the granted slot, clear the released slot. The two
  // can never coincide since one is free and the other occupied.
  always_comb begin
    occ_next = occ_q;
    if (alloc_fire) begin
      occ_next[alloc_idx] = 1'b1;
    end
    if (rel_hit) begin
      occ_next[rel_sel] = 1'b0;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_next;
    end
  end

  // Occupied-slot counter: allocate and release in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      unique case ({alloc_fire, rel_hit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Error pulse for a release that found nothing to free.
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_err_q <= 1'b0;
    end else begin
      rel_err_q <= rel_miss;
    end
  end

  // Payload storage; not reset, contents of free slots are don't-care.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      payload[alloc_idx] <= alloc_data;
    end
  end

  assign occupancy = occ_q;
  assign count     = count_q;
  assign rel_err   = rel_err_q;

`ifndef SYNTHESIS
  // The counter must always agree with the occupancy vector.
  a_count_matches_occ : assert property (
    @(posedge clk) disable iff (reset)
      count_q == ($countones(occ_q))
  );

  // An allocate must never be granted while full.
  a_no_alloc_when_full : assert property (
    @(posedge clk) disable iff (reset)
      !(alloc_fire && full)
  );
`endif

endmodule
